timer_bank: RTL

Parametrised bank of `NUM_CH` independent memory-mapped timers that replaces the single fixed timer in the peripheral subsystem.
- Each channel has configurable width, a per-channel prescaler, auto-reload or one-shot mode, and its own interrupt pending/enable bits.
- The bank drives one combined `irq` line into the CPU interrupt logic.
- It sits on the same load/store peripheral bus as the LED, switch and UART registers.
- Chip-select decode is done upstream, so the block sees only rd/wr strobes and a byte offset.

---
 rtl/timer_bank.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/timer_bank.sv
// timer_bank: NUM_CH memory-mapped timers with per-channel prescaler,
// auto-reload/one-shot mode, pending/enable bits and one combined irq.
// Ports: clk, reset (async, active-high), rd/wr strobes, addr byte offset,
// wdata in, rdata out (combinational, 0 when rd=0), irq out.
module timer_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [WIDTH-1:0] TL_MAX = '1;
  localparam logic [WIDTH-1:0] TL_ONE = WIDTH'(1);

  logic [WIDTH-1:0]  th_q [NUM_CH];
  logic [WIDTH-1:0]  th_d [NUM_CH];
  logic [WIDTH-1:0]  tl_q [NUM_CH];
  logic [WIDTH-1:0]  tl_d [NUM_CH];
  logic [7:0]        ps_q [NUM_CH];
  logic [7:0]        ps_d [NUM_CH];
  logic [7:0]        pc_q [NUM_CH];
  logic [7:0]        pc_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] ie_q, ie_d;
  logic [NUM_CH-1:0] os_q, os_d;
  logic [NUM_CH-1:0] pend_q, pend_d;

  logic [NUM_CH-1:0] wr_th, wr_tl, wr_ctrl;
  logic [NUM_CH-1:0] tick, ovf;

  logic [3:0] ch_sel;
  logic [1:0] reg_sel;
  logic       unused_ok;

  assign ch_sel    = addr[7:4];
  assign reg_sel   = addr[3:2];
  assign unused_ok = ^{addr[1:0], wdata};

  always_comb begin
    wr_th   = '0;
    wr_tl   = '0;
    wr_ctrl = '0;
    tick    = '0;
    ovf     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_th[c]   = wr && (ch_sel == 4'(c)) && (reg_sel == 2'd0);
      wr_tl[c]   = wr && (ch_sel == 4'(c)) && (reg_sel == 2'd1);
      wr_ctrl[c] = wr && (ch_sel == 4'(c)) && (reg_sel == 2'd2);
      tick[c]    = en_q[c] && (pc_q[c] == ps_q[c]);
      // A TL write in the same cycle swallows the tick, overflow included.
      ovf[c]     = tick[c] && (tl_q[c] == TL_MAX) && !wr_tl[c];
    end
  end

  always_comb begin
    en_d   = en_q;
    ie_d   = ie_q;
    os_d   = os_q;
    pend_d = pend_q;
    for (int c = 0; c < NUM_CH; c++) begin
      th_d[c] = th_q[c];
      tl_d[c] = tl_q[c];
      ps_d[c] = ps_q[c];
      pc_d[c] = pc_q[c] + 8'd1;
      if (!en_q[c] || tick[c] || wr_ctrl[c])
        pc_d[c] = 8'd0;

      if (wr_th[c])
        th_d[c] = wdata[WIDTH-1:0];

      if (wr_tl[c])
        tl_d[c] = wdata[WIDTH-1:0];
      else if (ovf[c])
        tl_d[c] = th_q[c];
      else if (tick[c])
        tl_d[c] = tl_q[c] + TL_ONE;

      if (wr_ctrl[c]) begin
        en_d[c] = wdata[0];
        ie_d[c] = wdata[1];
        os_d[c] = wdata[2];
        ps_d[c] = wdata[15:8];
      end else if (ovf[c] && os_q[c]) begin
        en_d[c] = 1'b0;
      end

      // Overflow set beats a simultaneous write-1-to-clear.
      if (ovf[c])
        pend_d[c] = 1'b1;
      else if (wr_ctrl[c] && wdata[3])
        pend_d[c] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= '{default: '0};
      tl_q   <= '{default: '0};
      ps_q   <= '{default: '0};
      pc_q   <= '{default: '0};
      en_q   <= '0;
      ie_q   <= '0;
      os_q   <= '0;
      pend_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      ps_q   <= ps_d;
      pc_q   <= pc_d;
      en_q   <= en_d;
      ie_q   <= ie_d;
      os_q   <= os_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (addr[7:2] == 6'h3C) begin
        rdata = 32'(pend_q);
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_sel == 4'(c)) begin
            case (reg_sel)
              2'd0:    rdata = 32'(th_q[c]);
              2'd1:    rdata = 32'(tl_q[c]);
              2'd2:    rdata = {16'b0, ps_q[c], 4'b0, pend_q[c],
                                os_q[c], ie_q[c], en_q[c]};
              default: rdata = '0;
            endcase
          end
        end
      end
    end
  end

  assign irq = |(pend_q & ie_q);

endmodule
